// File: rtl/text_row_reader_if.sv
// ---------------------------------------------------------------------------
// text_row_reader_if
//   SDRAM read-burst bus between the text row reader and the memory
//   controller.
//   master (row reader) : drives rd_address, rd_request, rd_burst_length;
//                         receives rd_data, rd_data_valid, rd_done
//   slave  (controller) : the mirror image
// ---------------------------------------------------------------------------
interface text_row_reader_if;
  logic [22:0] rd_address;
  logic        rd_request;
  logic [8:0]  rd_burst_length;
  logic [31:0] rd_data;
  logic        rd_data_valid;
  logic        rd_done;

  modport master (
    output rd_address, rd_request, rd_burst_length,
    input  rd_data, rd_data_valid, rd_done
  );

  modport slave (
    input  rd_address, rd_request, rd_burst_length,
    output rd_data, rd_data_valid, rd_done
  );
endinterface

// File: rtl/text_row_reader.sv
// ---------------------------------------------------------------------------
// text_row_reader
//   Fetches one text row of 32-bit character cells from SDRAM into the back
//   half of a ping-pong line buffer while the pixel generator reads the
//   front half. Cell byte address = {8'b0, phys_row, col, 2'b00}, where
//   phys_row is the logical row offset by the scroll register and wrapped
//   at ROWS.
//
//   clk, reset         clock, synchronous active-high reset
//   start, start_row   pulse: fetch logical row start_row into the back bank
//   first_row_address  scroll register; bits [14:9] are the first phys row
//   swap               pulse at a display line boundary: promote back bank
//   rd                 SDRAM read-burst bus (master side)
//   cell_column        display-side column select
//   cell_data          front-bank cell, one cycle after cell_column
//   busy               from accepted start until the final rd_done
//   line_ready         one-cycle pulse when the back bank is full
//   overrun, underrun  sticky error flags, cleared only by reset
// ---------------------------------------------------------------------------
module text_row_reader #(
  parameter int COLUMNS = 80,
  parameter int ROWS    = 51,
  parameter int BURST   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [5:0]           start_row,
  input  logic [22:0]          first_row_address,
  input  logic                 swap,
  text_row_reader_if.master    rd,
  input  logic [6:0]           cell_column,
  output logic [31:0]          cell_data,
  output logic                 busy,
  output logic                 line_ready,
  output logic                 overrun,
  output logic                 underrun
);

  localparam int                ADDR_W  = $clog2(2 * COLUMNS);
  localparam logic [7:0]        COLS_8  = 8'(COLUMNS);
  localparam logic [6:0]        COLS_7  = 7'(COLUMNS);
  localparam logic [7:0]        BURST_8 = 8'(BURST);
  localparam logic [6:0]        ROWS_7  = 7'(ROWS);
  localparam logic [ADDR_W-1:0] COLS_A  = ADDR_W'(COLUMNS);

  typedef enum logic [1:0] {IDLE, REQUEST, WAIT} state_e;

  state_e      state_q;
  logic [5:0]  phys_q;
  logic [6:0]  col_q;
  logic [7:0]  idx_q;
  logic        front_q;
  logic        complete_q;
  logic        busy_q;
  logic        line_ready_q;
  logic        overrun_q;
  logic        underrun_q;
  logic        rd_request_q;
  logic [22:0] rd_address_q;
  logic [31:0] cell_data_q;
  logic [31:0] mem_q [2*COLUMNS];

  logic [6:0]        row_sum;
  logic [5:0]        phys_d;
  logic [7:0]        col_next;
  logic [6:0]        col_d;
  logic              last_burst;
  logic              start_ok;
  logic              final_done;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;

  // Only the row field of the scroll register matters here.
  logic unused_fra;
  assign unused_fra = ^{first_row_address[22:15], first_row_address[8:0]};

  // NOTE: every signal gets a value on every path through always_comb;
  // a missing assignment would infer a latch.
  always_comb begin
    row_sum    = {1'b0, start_row} + {1'b0, first_row_address[14:9]};
    phys_d     = (row_sum >= ROWS_7) ? 6'(row_sum - ROWS_7) : row_sum[5:0];
    col_next   = {1'b0, col_q} + BURST_8;
    col_d      = col_next[6:0];
    last_burst = (col_next >= COLS_8);
    start_ok   = start && !busy_q && ({1'b0, start_row} < ROWS_7);
    final_done = (state_q == WAIT) && rd.rd_done && last_burst;
    // Words past the end of the row are dropped, never written out of range.
    wr_en      = (state_q == WAIT) && rd.rd_data_valid && (idx_q < COLS_8);
    // Back bank is the one the display is not reading.
    wr_addr    = (front_q ? '0 : COLS_A) + ADDR_W'(idx_q);
    rd_addr    = (front_q ? COLS_A : '0) + ADDR_W'(cell_column);
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      phys_q       <= '0;
      col_q        <= '0;
      idx_q        <= '0;
      front_q      <= 1'b0;
      complete_q   <= 1'b0;
      busy_q       <= 1'b0;
      line_ready_q <= 1'b0;
      overrun_q    <= 1'b0;
      underrun_q   <= 1'b0;
      rd_request_q <= 1'b0;
      rd_address_q <= '0;
    end else begin
      line_ready_q <= 1'b0;
      rd_request_q <= 1'b0;

      // Swap is resolved first; a burst finishing this very cycle counts
      // as a complete back bank.
      if (swap) begin
        if (complete_q || final_done) begin
          front_q    <= ~front_q;
          complete_q <= 1'b0;
        end else begin
          underrun_q <= 1'b1;
        end
      end

      if (start && !start_ok) overrun_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (start_ok) begin
            phys_q       <= phys_d;
            col_q        <= '0;
            idx_q        <= '0;
            complete_q   <= 1'b0;
            busy_q       <= 1'b1;
            rd_request_q <= 1'b1;
            rd_address_q <= {8'b0, phys_d, 7'b0, 2'b00};
            state_q      <= REQUEST;
          end
        end
        REQUEST: state_q <= WAIT;
        WAIT: begin
          if (wr_en) idx_q <= idx_q + 8'd1;
          if (rd.rd_done) begin
            if (last_burst) begin
              // A coincident swap has already consumed this line.
              complete_q   <= !swap;
              line_ready_q <= 1'b1;
              busy_q       <= 1'b0;
              state_q      <= IDLE;
            end else begin
              col_q        <= col_d;
              rd_request_q <= 1'b1;
              rd_address_q <= {8'b0, phys_q, col_d, 2'b00};
              state_q      <= REQUEST;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: the line buffer has no reset; the complete flag decides whether
  // its contents are meaningful, so partial data after a reset is harmless.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= rd.rd_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cell_data_q <= '0;
    end else if (cell_column < COLS_7) begin
      cell_data_q <= mem_q[rd_addr];
    end else begin
      cell_data_q <= '0;
    end
  end

  assign rd.rd_address      = rd_address_q;
  assign rd.rd_request      = rd_request_q;
  assign rd.rd_burst_length = 9'(BURST);
  assign cell_data          = cell_data_q;
  assign busy               = busy_q;
  assign line_ready         = line_ready_q;
  assign overrun            = overrun_q;
  assign underrun           = underrun_q;

endmodule

// File: tb/tb_text_row_reader.sv
// ---------------------------------------------------------------------------
// tb_text_row_reader
//   Self-checking bench for text_row_reader. A table of row fetches is run
//   against a behavioural SDRAM responder that returns data = word address;
//   expected burst addresses go into a scoreboard queue when a fetch is
//   started and are popped as requests appear. Hand-written sequences cover
//   overrun, underrun, swap/done coincidence and reset mid-burst.
// ---------------------------------------------------------------------------
module tb_text_row_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  start_row;
  logic [22:0] first_row_address;
  logic        swap;
  logic [6:0]  cell_column;
  logic [31:0] cell_data;
  logic        busy;
  logic        line_ready;
  logic        overrun;
  logic        underrun;

  text_row_reader_if bus();

  text_row_reader dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .start_row         (start_row),
    .first_row_address (first_row_address),
    .swap              (swap),
    .rd                (bus),
    .cell_column       (cell_column),
    .cell_data         (cell_data),
    .busy              (busy),
    .line_ready        (line_ready),
    .overrun           (overrun),
    .underrun          (underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] row;
    logic [5:0] fro;
    logic [5:0] phys;
    int         extra;
    bit         dwl;
  } vec_t;

  vec_t        vecs [6];
  int          disp [4];
  logic [22:0] exp_q [$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          req_cnt = 0;
  int          lr_cnt = 0;

  always @(posedge clk) begin
    if (bus.rd_request) req_cnt <= req_cnt + 1;
    if (line_ready)     lr_cnt  <= lr_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] cell_val(input logic [5:0] phys, input int c);
    return (c < 80) ? {17'b0, phys, 7'(c), 2'b00} : 32'h0;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_rd_request"}, 32'(bus.rd_request), 32'd0);
    check({tag, "_rd_address"}, 32'(bus.rd_address), 32'd0);
    check({tag, "_burst_len"},  32'(bus.rd_burst_length), 32'd16);
    check({tag, "_busy"},       32'(busy), 32'd0);
    check({tag, "_line_ready"}, 32'(line_ready), 32'd0);
    check({tag, "_overrun"},    32'(overrun), 32'd0);
    check({tag, "_underrun"},   32'(underrun), 32'd0);
    check({tag, "_cell_data"},  cell_data, 32'd0);
  endtask

  task automatic push_fetch(input logic [5:0] phys);
    for (int b = 0; b < 5; b++) exp_q.push_back({8'b0, phys, 7'(b * 16), 2'b00});
  endtask

  task automatic start_fetch(input logic [5:0] row, input logic [5:0] fro);
    start_row         = row;
    first_row_address = {8'hA5, fro, 9'h1C3};
    start             = 1'b1;
    tick();
    start             = 1'b0;
    // Scramble: the DUT must have sampled these on the start cycle.
    start_row         = 6'h2A;
    first_row_address = 23'h7FFFFF;
  endtask

  task automatic send_done(input bit swap_w);
    bus.rd_done = 1'b1;
    swap        = swap_w;
    tick();
    bus.rd_done = 1'b0;
    swap        = 1'b0;
  endtask

  // done_mode: 0 = rd_done the cycle after the last word,
  //            1 = rd_done with the last word, 2 = no rd_done
  task automatic serve_burst(input int nwords, input int done_mode, input bit swap_w);
    int          k;
    logic [22:0] e;
    k = 0;
    while (!bus.rd_request && k < 20) begin
      tick();
      k++;
    end
    if (!bus.rd_request) begin
      n_cmp++;
      n_fail++;
      $display("FAIL req_timeout: no rd_request after %0d cycles, expected one", k);
      return;
    end
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL unexpected_req: rd_address 0x%0h, expected no request", bus.rd_address);
      e = bus.rd_address;
    end else begin
      e = exp_q.pop_front();
      check("rd_address", 32'(bus.rd_address), 32'(e));
    end
    tick();
    for (int i = 0; i < nwords; i++) begin
      bus.rd_data       = 32'(e) + 32'(4 * i);
      bus.rd_data_valid = 1'b1;
      bus.rd_done       = (done_mode == 1) && (i == nwords - 1);
      swap              = bus.rd_done && swap_w;
      tick();
    end
    bus.rd_data_valid = 1'b0;
    bus.rd_done       = 1'b0;
    swap              = 1'b0;
    if (done_mode == 0) send_done(swap_w);
  endtask

  task automatic full_fetch(input logic [5:0] row, input logic [5:0] fro, input logic [5:0] phys,
                            input int extra, input bit dwl, input bit swap_w);
    int r0;
    int l0;
    r0 = req_cnt;
    l0 = lr_cnt;
    push_fetch(phys);
    start_fetch(row, fro);
    for (int b = 0; b < 5; b++)
      serve_burst((b == 4) ? 16 + extra : 16, (b == 4) ? int'(dwl) : b % 2, swap_w && (b == 4));
    check("line_ready_pulse", 32'(line_ready), 32'd1);
    check("busy_after_fetch", 32'(busy), 32'd0);
    tick();
    check("line_ready_width", 32'(line_ready), 32'd0);
    check("line_ready_count", 32'(lr_cnt - l0), 32'd1);
    check("request_count", 32'(req_cnt - r0), 32'd5);
  endtask

  task automatic do_swap();
    swap = 1'b1;
    tick();
    swap = 1'b0;
  endtask

  task automatic read_cell(input int c, input logic [5:0] phys, input string name);
    cell_column = 7'(c);
    tick();
    check(name, cell_data, cell_val(phys, c));
    cell_column = 7'd100;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    int r0;

    //           row    fro    phys   extra dwl
    vecs[0] = '{6'd0,  6'd0,  6'd0,  0,    1'b0};
    vecs[1] = '{6'd3,  6'd50, 6'd2,  0,    1'b1};
    vecs[2] = '{6'd50, 6'd1,  6'd0,  2,    1'b1};
    vecs[3] = '{6'd10, 6'd20, 6'd30, 2,    1'b0};
    vecs[4] = '{6'd40, 6'd40, 6'd29, 0,    1'b0};
    vecs[5] = '{6'd0,  6'd63, 6'd12, 0,    1'b1};
    disp    = '{0, 37, 79, 100};

    reset             = 1'b1;
    start             = 1'b0;
    start_row         = '0;
    first_row_address = '0;
    swap              = 1'b0;
    cell_column       = 7'd100;
    bus.rd_data       = '0;
    bus.rd_data_valid = 1'b0;
    bus.rd_done       = 1'b0;
    tick();
    tick();
    check_reset_vals("reset");
    reset = 1'b0;
    tick();
    check("idle_cell_data", cell_data, 32'd0);

    // Table of full-row fetches, each followed by a swap and display reads.
    for (int i = 0; i < 6; i++) begin
      full_fetch(vecs[i].row, vecs[i].fro, vecs[i].phys, vecs[i].extra, vecs[i].dwl, 1'b0);
      if (i > 0) read_cell(0, vecs[i-1].phys, "front_before_swap");
      do_swap();
      for (int d = 0; d < 4; d++) read_cell(disp[d], vecs[i].phys, "cell");
    end
    check("overrun_clean", 32'(overrun), 32'd0);
    check("underrun_clean", 32'(underrun), 32'd0);

    // Start while busy is rejected and does not disturb the fetch.
    r0 = req_cnt;
    push_fetch(6'd5);
    start_fetch(6'd5, 6'd0);
    serve_burst(16, 2, 1'b0);
    start_fetch(6'd7, 6'd0);
    check("overrun_busy", 32'(overrun), 32'd1);
    check("busy_kept", 32'(busy), 32'd1);
    send_done(1'b0);
    for (int b = 1; b < 5; b++) serve_burst(16, 0, 1'b0);
    check("busy_fetch_done", 32'(line_ready), 32'd1);
    tick();
    check("busy_fetch_requests", 32'(req_cnt - r0), 32'd5);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // Out-of-range start row.
    reset_dut();
    check("overrun_cleared", 32'(overrun), 32'd0);
    r0 = req_cnt;
    start_fetch(6'd51, 6'd0);
    repeat (4) tick();
    check("overrun_row51", 32'(overrun), 32'd1);
    check("busy_row51", 32'(busy), 32'd0);
    check("requests_row51", 32'(req_cnt - r0), 32'd0);

    // Swap coincident with the final rd_done, then a premature swap.
    reset_dut();
    full_fetch(6'd7, 6'd0, 6'd7, 0, 1'b0, 1'b1);
    check("underrun_coincident", 32'(underrun), 32'd0);
    read_cell(5, 6'd7, "cell_after_coincident");
    push_fetch(6'd9);
    start_fetch(6'd9, 6'd0);
    serve_burst(16, 0, 1'b0);
    serve_burst(16, 2, 1'b0);
    do_swap();
    check("underrun_early", 32'(underrun), 32'd1);
    read_cell(5, 6'd7, "front_unchanged");
    send_done(1'b0);
    for (int b = 2; b < 5; b++) serve_burst(16, 0, 1'b0);
    check("late_line_ready", 32'(line_ready), 32'd1);
    tick();
    do_swap();
    read_cell(5, 6'd9, "cell_after_late_swap");

    // Reset in the middle of a burst.
    push_fetch(6'd4);
    start_fetch(6'd4, 6'd0);
    serve_burst(7, 2, 1'b0);
    reset = 1'b1;
    tick();
    check_reset_vals("mid_reset");
    reset = 1'b0;
    exp_q.delete();
    r0 = req_cnt;
    bus.rd_done       = 1'b1;
    bus.rd_data_valid = 1'b1;
    tick();
    bus.rd_done       = 1'b0;
    bus.rd_data_valid = 1'b0;
    repeat (4) tick();
    check("late_done_busy", 32'(busy), 32'd0);
    check("late_done_requests", 32'(req_cnt - r0), 32'd0);
    full_fetch(6'd4, 6'd0, 6'd4, 0, 1'b0, 1'b0);
    do_swap();
    read_cell(3, 6'd4, "cell_after_refetch");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
